sc_cordic_mult_arbiter: RTL

//  Round-robin arbiter and sequencer that shares the velocity CORDIC + multiplier chain among N_REQ requesters.

---
 rtl/sc_cordic_mult_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sc_cordic_mult_arbiter.sv
// sc_cordic_mult_arbiter: round-robin share of one CORDIC + multiplier chain.
// Sequences init/validin/start per grant; returns done or a timeout error.
module sc_cordic_mult_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ANGLE_W        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     SC_CORDIC_ARB_CLOCK_50,
  input  logic                     SC_CORDIC_ARB_RESET_InLow,
  input  logic [N_REQ-1:0]         SC_CORDIC_ARB_req_InHigh,
  input  logic [N_REQ*ANGLE_W-1:0] SC_CORDIC_ARB_angle_In,
  input  logic                     SC_CORDIC_ARB_valid_cordic_InHigh,
  input  logic                     SC_CORDIC_ARB_complete_InHigh,
  output logic                     SC_CORDIC_ARB_init_cordic_Out,
  output logic                     SC_CORDIC_ARB_validin_cordic_Out,
  output logic                     SC_CORDIC_ARB_start_multiply_Out,
  output logic [ANGLE_W-1:0]       SC_CORDIC_ARB_angle_Out,
  output logic [N_REQ-1:0]         SC_CORDIC_ARB_grant_Out,
  output logic [N_REQ-1:0]         SC_CORDIC_ARB_done_Out,
  output logic                     SC_CORDIC_ARB_error_Out,
  output logic                     SC_CORDIC_ARB_busy_Out
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, GRANT, INIT, VALIDIN, WAIT_CORDIC,
    START_MULT, WAIT_MULT, DONE, ERR
  } state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      idx_nxt;
  logic               found;
  logic [CW-1:0]      cnt;
  logic               cnt_end;
  logic [ANGLE_W-1:0] angle;

  // circular first-set search starting at the round-robin pointer
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      automatic int j = (int'(ptr) + k) % N_REQ;
      if (!found && SC_CORDIC_ARB_req_InHigh[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign cnt_end = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign idx_nxt = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge SC_CORDIC_ARB_CLOCK_50 or
              negedge SC_CORDIC_ARB_RESET_InLow) begin
    if (!SC_CORDIC_ARB_RESET_InLow) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      angle <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          idx   <= pick;
          angle <= SC_CORDIC_ARB_angle_In[pick*ANGLE_W +: ANGLE_W];
          state <= GRANT;
        end
        GRANT: state <= INIT;
        INIT:  state <= VALIDIN;
        VALIDIN: begin
          cnt   <= '0;
          state <= WAIT_CORDIC;
        end
        WAIT_CORDIC: begin
          if (SC_CORDIC_ARB_valid_cordic_InHigh) state <= START_MULT;
          else if (cnt_end)                      state <= ERR;
          else                                   cnt   <= cnt + 1'b1;
        end
        START_MULT: begin
          cnt   <= '0;
          state <= WAIT_MULT;
        end
        WAIT_MULT: begin
          if (SC_CORDIC_ARB_complete_InHigh) state <= DONE;
          else if (cnt_end)                  state <= ERR;
          else                               cnt   <= cnt + 1'b1;
        end
        DONE, ERR: begin
          ptr   <= idx_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SC_CORDIC_ARB_init_cordic_Out    = (state == INIT);
  assign SC_CORDIC_ARB_validin_cordic_Out = (state == VALIDIN);
  assign SC_CORDIC_ARB_start_multiply_Out = (state == START_MULT);
  assign SC_CORDIC_ARB_error_Out          = (state == ERR);
  assign SC_CORDIC_ARB_busy_Out           = (state != IDLE);
  assign SC_CORDIC_ARB_angle_Out          = angle;

  always_comb begin
    SC_CORDIC_ARB_grant_Out = '0;
    SC_CORDIC_ARB_done_Out  = '0;
    if (state != IDLE) SC_CORDIC_ARB_grant_Out[idx] = 1'b1;
    if (state == DONE) SC_CORDIC_ARB_done_Out[idx]  = 1'b1;
  end
endmodule
